// File: rtl/punc_defines_pkg.sv
// Shared PUNC definitions: opcodes, FSM state encodings, datapath select encodings
// and the control vector handed from the decoder to the datapath.
package punc_defines;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [1:0] PC_SEL_INC   = 2'd0;
    localparam logic [1:0] PC_SEL_OFF   = 2'd1;
    localparam logic [1:0] PC_SEL_BASE  = 2'd2;

    localparam logic [1:0] MA_PC        = 2'd0;
    localparam logic [1:0] MA_PC_OFF    = 2'd1;
    localparam logic [1:0] MA_BASE_OFF  = 2'd2;
    localparam logic [1:0] MA_INDIRECT  = 2'd3;

    localparam logic [1:0] WD_ALU       = 2'd0;
    localparam logic [1:0] WD_MEM       = 2'd1;
    localparam logic [1:0] WD_PC_OFF    = 2'd2;
    localparam logic [1:0] WD_PC        = 2'd3;

    localparam logic [1:0] ALU_ADD      = 2'd0;
    localparam logic [1:0] ALU_AND      = 2'd1;
    localparam logic [1:0] ALU_NOT      = 2'd2;
    localparam logic [1:0] ALU_PASS     = 2'd3;

    localparam logic [1:0] SEXT_IMM5    = 2'd0;
    localparam logic [1:0] SEXT_OFF6    = 2'd1;
    localparam logic [1:0] SEXT_OFF9    = 2'd2;
    localparam logic [1:0] SEXT_OFF11   = 2'd3;

    typedef struct packed {
        logic       ir_ld;
        logic       pc_ld;
        logic [1:0] pc_sel;
        logic [1:0] mem_addr_sel;
        logic       mem_w_en;
        logic       rf_w_en;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] alu_sel;
        logic       alu_b_sel;
        logic [1:0] sext_sel;
        logic       nzp_ld;
    } ctrl_t;

    // Opcodes that stop the machine from DECODE; indirect ops join them when not built in.
    function automatic logic op_halts(input logic [3:0] op);
        logic h;
        h = (op == OP_TRAP) || (op == OP_RTI) || (op == OP_RES);
`ifndef PUNC_INDIRECT_EN
        h = h || (op == OP_LDI) || (op == OP_STI);
`endif
        return h;
    endfunction

endpackage

// File: rtl/punc_decode.sv
// Combinational state/opcode to control-vector lookup for punc_control.
// PUNC_INDIRECT_EN adds the LDI/STI EXEC and EXEC2 rows.
module punc_decode
    import punc_defines::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic [2:0]  nzp,
    output ctrl_t       ctrl
);

    logic [3:0] op;
    assign op = ir[15:12];

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_addr_sel = MA_PC;
                ctrl.ir_ld        = 1'b1;
                ctrl.pc_ld        = 1'b1;
                ctrl.pc_sel       = PC_SEL_INC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_AND: begin
                        ctrl.alu_sel   = (op == OP_AND) ? ALU_AND : ALU_ADD;
                        ctrl.alu_b_sel = ir[5];
                        ctrl.sext_sel  = SEXT_IMM5;
                        ctrl.rf_w_en   = 1'b1;
                        ctrl.nzp_ld    = 1'b1;
                    end
                    OP_NOT: begin
                        ctrl.alu_sel = ALU_NOT;
                        ctrl.rf_w_en = 1'b1;
                        ctrl.nzp_ld  = 1'b1;
                    end
                    OP_BR: begin
                        ctrl.pc_ld    = |(ir[11:9] & nzp);
                        ctrl.pc_sel   = PC_SEL_OFF;
                        ctrl.sext_sel = SEXT_OFF9;
                    end
                    OP_JMP: begin
                        ctrl.pc_ld  = 1'b1;
                        ctrl.pc_sel = PC_SEL_BASE;
                    end
                    OP_JSR: begin
                        // R7 gets the PC already bumped in FETCH, written alongside the jump.
                        ctrl.rf_w_en       = 1'b1;
                        ctrl.rf_w_addr_sel = 1'b1;
                        ctrl.rf_w_data_sel = WD_PC;
                        ctrl.pc_ld         = 1'b1;
                        ctrl.pc_sel        = ir[11] ? PC_SEL_OFF : PC_SEL_BASE;
                        ctrl.sext_sel      = ir[11] ? SEXT_OFF11 : SEXT_IMM5;
                    end
                    OP_LD, OP_LDR: begin
                        ctrl.mem_addr_sel  = (op == OP_LDR) ? MA_BASE_OFF : MA_PC_OFF;
                        ctrl.sext_sel      = (op == OP_LDR) ? SEXT_OFF6 : SEXT_OFF9;
                        ctrl.rf_w_data_sel = WD_MEM;
                        ctrl.rf_w_en       = 1'b1;
                        ctrl.nzp_ld        = 1'b1;
                    end
                    OP_LEA: begin
                        ctrl.rf_w_data_sel = WD_PC_OFF;
                        ctrl.sext_sel      = SEXT_OFF9;
                        ctrl.rf_w_en       = 1'b1;
                        ctrl.nzp_ld        = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        ctrl.mem_addr_sel   = (op == OP_STR) ? MA_BASE_OFF : MA_PC_OFF;
                        ctrl.sext_sel       = (op == OP_STR) ? SEXT_OFF6 : SEXT_OFF9;
                        ctrl.rf_r1_addr_sel = 1'b1;
                        ctrl.mem_w_en       = 1'b1;
                    end
`ifdef PUNC_INDIRECT_EN
                    OP_LDI, OP_STI: begin
                        ctrl.mem_addr_sel = MA_PC_OFF;
                        ctrl.sext_sel     = SEXT_OFF9;
                    end
`endif
                    default: ;
                endcase
            end
`ifdef PUNC_INDIRECT_EN
            S_EXEC2: begin
                ctrl.mem_addr_sel = MA_INDIRECT;
                if (op == OP_LDI) begin
                    ctrl.rf_w_en       = 1'b1;
                    ctrl.rf_w_data_sel = WD_MEM;
                    ctrl.nzp_ld        = 1'b1;
                end else begin
                    ctrl.mem_w_en       = 1'b1;
                    ctrl.rf_r1_addr_sel = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/punc_control.sv
// PUNC multi-cycle control FSM: FETCH -> DECODE -> EXEC [-> EXEC2] with a sticky HALT.
// Build with PUNC_INDIRECT_EN to enable LDI/STI and the EXEC2 state.
module punc_control
    import punc_defines::*;
#(
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [2:0]  nzp,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic [1:0]  pc_sel,
    output logic [1:0]  mem_addr_sel,
    output logic        mem_w_en,
    output logic        rf_w_en,
    output logic        rf_w_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_r1_addr_sel,
    output logic [1:0]  alu_sel,
    output logic        alu_b_sel,
    output logic [1:0]  sext_sel,
    output logic        nzp_ld,
    output logic        halted,
    output logic [2:0]  state
);

    state_t state_q, state_d;
    logic   halted_q, halted_d;
    ctrl_t  dec_ctrl, ctrl;
    logic [3:0] op;

    assign op = ir[15:12];

    punc_decode u_decode (
        .state (state_q),
        .ir    (ir),
        .nzp   (nzp),
        .ctrl  (dec_ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = op_halts(op) ? S_HALT : S_EXEC;
`ifdef PUNC_INDIRECT_EN
            S_EXEC:   state_d = (op == OP_LDI || op == OP_STI) ? S_EXEC2 : S_FETCH;
            S_EXEC2:  state_d = S_FETCH;
`else
            S_EXEC:   state_d = S_FETCH;
`endif
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Reset masks the FETCH strobes combinationally so nothing writes while rst is high.
    always_comb begin
        ctrl = dec_ctrl;
        if (rst) begin
            ctrl        = '0;
            ctrl.pc_sel = RESET_PC_SEL;
        end
    end

    assign ir_ld          = ctrl.ir_ld;
    assign pc_ld          = ctrl.pc_ld;
    assign pc_sel         = ctrl.pc_sel;
    assign mem_addr_sel   = ctrl.mem_addr_sel;
    assign mem_w_en       = ctrl.mem_w_en;
    assign rf_w_en        = ctrl.rf_w_en;
    assign rf_w_addr_sel  = ctrl.rf_w_addr_sel;
    assign rf_w_data_sel  = ctrl.rf_w_data_sel;
    assign rf_r1_addr_sel = ctrl.rf_r1_addr_sel;
    assign alu_sel        = ctrl.alu_sel;
    assign alu_b_sel      = ctrl.alu_b_sel;
    assign sext_sel       = ctrl.sext_sel;
    assign nzp_ld         = ctrl.nzp_ld;
    assign halted         = halted_q;
    assign state          = state_q;

endmodule
